shiftadd_multiplier: RTL

- Sequential shift-add multiply-accumulate unit computing P = DataA*DataB + DataC over N cycles.
- Companion to longdivider and the inverse operation: recomposes numerator = quotient*divisor + remainder.
- Used by the divider self-check bench and the datapath recomposition path.
- Same handshake as longdivider: s/LA/EB load-and-start controls, Moore Done output.

---
 rtl/shiftadd_multiplier_pkg.sv | 14 +
 rtl/shiftadd_multiplier_if.sv | 29 ++
 rtl/shiftrne_lr.sv | 27 ++
 rtl/shiftadd_multiplier.sv | 97 +++++++++
 4 files changed

// File: rtl/shiftadd_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier and the long divider control.
// Pure declarations: no latency, no flow control.
// State encoding is common so both units can be monitored identically.
package mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        S1 = 2'd0,
        S2 = 2'd1,
        S3 = 2'd2
    } state_t;

endpackage

// File: rtl/shiftadd_multiplier_if.sv
// Operand/result bundle between a requester and the shift-add multiplier.
// Latency: none (wires only).
// Backpressure: none; the requester holds s high until it has consumed P.
interface shiftadd_multiplier_if
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) ();

    logic             s;
    logic             LA;
    logic             EB;
    logic [N-1:0]     DataA;
    logic [N-1:0]     DataB;
    logic [N-1:0]     DataC;
    logic [2*N-1:0]   P;
    logic             Done;

    modport master (
        output s, LA, EB, DataA, DataB, DataC,
        input  P, Done
    );

    modport slave (
        input  s, LA, EB, DataA, DataB, DataC,
        output P, Done
    );

endinterface

// File: rtl/shiftrne_lr.sv
// Loadable W-bit shift register with enable; shifts left or right by one, zero fill.
// Latency: 1 cycle from ld/en to q.
// Backpressure: none; ld takes priority over en.
module shiftrne_lr #(
    parameter int   W    = 8,
    parameter logic LEFT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            if (LEFT) q <= q << 1;
            else      q <= q >> 1;
        end
    end

endmodule

// File: rtl/shiftadd_multiplier.sv
// Sequential unsigned multiply-accumulate: P = DataA*DataB + DataC over N steps.
// Latency: N cycles from the edge that samples s=1 in S1 to Done=1.
// Backpressure: Done/P held in S3 while s stays high; dropping s returns to S1.
module shiftadd_multiplier
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    shiftadd_multiplier_if.slave bus
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N);

    state_t          state;
    logic [CW-1:0]   count;
    logic [2*N-1:0]  p_acc;
    logic [2*N-1:0]  a_q;
    logic [N-1:0]    b_q;
    logic            done;

    logic            ld_a;
    logic            ld_b;
    logic            step;

    assign ld_a = (state == S1) && bus.LA;
    assign ld_b = (state == S1) && bus.EB;
    assign step = (state == S2);

    shiftrne_lr #(
        .W    (2*N),
        .LEFT (1'b1)
    ) u_shift_a (
        .clk   (Clock),
        .rst_n (Resetn),
        .ld    (ld_a),
        .en    (step),
        .d     ({{N{1'b0}}, bus.DataA}),
        .q     (a_q)
    );

    shiftrne_lr #(
        .W    (N),
        .LEFT (1'b0)
    ) u_shift_b (
        .clk   (Clock),
        .rst_n (Resetn),
        .ld    (ld_b),
        .en    (step),
        .d     (bus.DataB),
        .q     (b_q)
    );

    // The 2N-bit sum cannot overflow for unsigned N-bit operands plus an N-bit addend.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S1;
            count <= '0;
            p_acc <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                S1: begin
                    done  <= 1'b0;
                    count <= CNT_INIT;
                    if (bus.LA) p_acc <= {{N{1'b0}}, bus.DataC};
                    if (bus.s)  state <= S2;
                end
                S2: begin
                    if (b_q[0]) p_acc <= p_acc + a_q;
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= S3;
                        done  <= 1'b1;
                    end
                end
                S3: begin
                    if (!bus.s) begin
                        state <= S1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= S1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.P    = p_acc;
    assign bus.Done = done;

endmodule
